mole_spawner: RTL
=================

Name: mole_spawner

Overview:
- Game-side driver of the mole interface. Produces the mole_positions mask consumed by the hit detector and reacts to its hit/miss pulses.
- Alternates mole-down and mole-up rounds under a timer.
- Chooses distinct random holes with an LFSR.
- Ends a round early when the hit detector reports a full clear.

Parameters:
NUM_HOLES, 18, number of holes; width of mole_positions
DOWN_CYCLES, 50_000_000, clk cycles moles stay hidden between rounds
UP_CYCLES, 100_000_000, base clk cycles a round stays up at level 0
MAX_MOLES, 3, max moles per round (1..NUM_HOLES)
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
game_in_progress  input  1  high while a game is running
full_clear_hit  input  1  1-cycle pulse: last mole of round hit
non_full_clear_hit  input  1  1-cycle pulse: hit, moles remain (statistics only)
miss  input  1  1-cycle pulse: switch flipped on empty hole
level  input  3  difficulty; shortens up time
mole_positions  output  NUM_HOLES  one bit per hole with a mole up; all-zero outside UP
round_expired  output  1  1-cycle pulse: round timed out with moles remaining
round_count  output  8  rounds that entered UP this game, saturating at 255

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; mole_positions=0; round_expired=0; round_count=0.
  - Timers=0; pending mask=0; LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle after reset, in all states.
- IDLE:
  - mole_positions=0.
  - game_in_progress=1 -> DOWN next cycle; load down timer with DOWN_CYCLES-1; round_count=0.
- DOWN:
  - Timer decrements each cycle.
  - At 0 -> SPAWN; clear pending mask; target = 1 + (lfsr[15:8] mod MAX_MOLES); clear retry counter.
- SPAWN (one pick per cycle):
  - idx = lfsr[7:0] mod NUM_HOLES.
  - If pending[idx]=0: set it. Otherwise increment retry.
  - If retry reaches NUM_HOLES: set the lowest-index clear bit instead and reset retry.
  - When popcount(pending)==target -> UP.
  - mole_positions stays 0 throughout SPAWN, so the downstream rising edge presents the complete mask in a single cycle.
- UP:
  - mole_positions = pending mask, held constant for the whole round.
  - On entry, load up timer = max(1, UP_CYCLES >> level) - 1; level is sampled on the entry cycle only.
  - On entry, round_count += 1, saturating at 255.
- UP exits:
  - full_clear_hit=1 -> DOWN next cycle; mole_positions=0; down timer reloaded; no round_expired.
  - Up timer reaches 0 without a clear -> DOWN; round_expired=1 for exactly that transition cycle.
  - full_clear_hit on the same cycle the timer reaches 0 -> clear wins; round_expired stays 0.
  - non_full_clear_hit: no state effect.
  - miss: no state effect unless the optional feature is compiled in.
- game_in_progress=0 in any state:
  - -> IDLE next cycle; mole_positions=0; round_expired=0; pending cleared.
  - round_count holds its value until the next game start.
- rst mid-round: returns everything to reset values next edge, regardless of other inputs.
- All outputs registered; state change to visible mole_positions latency = 1 cycle.

Optional Feature:
- Macro: MOLE_HIDE_ON_MISS_EN.
- Defined: a miss pulse while in UP ends the round. Next cycle -> DOWN, mole_positions=0, round_expired=1 for one cycle.
- Defined, simultaneous full_clear_hit and miss: clear wins.
- Undefined: miss is ignored entirely.

Test Plan:
- Bench parameters: NUM_HOLES=18, DOWN_CYCLES=4, UP_CYCLES=16, MAX_MOLES=3.
- rst high 2 cycles, game_in_progress=1, level=0 -> mole_positions=0 for 4 DOWN cycles plus all SPAWN cycles. Then a nonzero mask with popcount 1..3 for exactly 16 cycles. Then round_expired=1 for one cycle, mask=0, round_count=1.
- In UP, pulse full_clear_hit at UP cycle 5 -> mask=0 next cycle, round_expired never asserted, next round appears after 4 DOWN cycles plus SPAWN.
- level=2 -> UP lasts 4 cycles; level=7 -> UP lasts 1 cycle (minimum clamp).
- Force full_clear_hit on the timer-expiry cycle -> round_expired stays 0. With MOLE_HIDE_ON_MISS_EN, a miss at UP cycle 3 -> mask=0 and round_expired=1 next cycle. Without the macro, the same miss -> no change.
- Drop game_in_progress mid-UP -> mask=0 next cycle, state IDLE. Run 300 rounds with immediate clears -> round_count saturates at 255. Every observed mask has popcount in 1..3 with distinct bits and never changes within a round.

Source files
------------

// File: rtl/mole_spawner_if.sv
// Mole interface between the game-side spawner and the hit detector.
// The spawner drives the mole mask and round status; the hit detector side drives hits, misses and game control.
interface mole_spawner_if #(
    parameter int NUM_HOLES = 18
);
    logic                 game_in_progress;
    logic                 full_clear_hit;
    logic                 non_full_clear_hit;
    logic                 miss;
    logic [2:0]           level;
    logic [NUM_HOLES-1:0] mole_positions;
    logic                 round_expired;
    logic [7:0]           round_count;

    modport master (
        input  game_in_progress, full_clear_hit, non_full_clear_hit, miss, level,
        output mole_positions, round_expired, round_count
    );

    modport slave (
        output game_in_progress, full_clear_hit, non_full_clear_hit, miss, level,
        input  mole_positions, round_expired, round_count
    );
endinterface

// File: rtl/mole_spawner.sv
// Mole spawner: alternates hidden and visible rounds, choosing distinct random holes with a Galois LFSR.
// Define MOLE_HIDE_ON_MISS_EN to make a miss during a visible round end that round as expired.
module mole_spawner #(
    parameter int          NUM_HOLES   = 18,
    parameter int          DOWN_CYCLES = 50_000_000,
    parameter int          UP_CYCLES   = 100_000_000,
    parameter int          MAX_MOLES   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    mole_spawner_if.master mif
);
    localparam int                CNT_W     = $clog2(NUM_HOLES + 1);
    localparam logic [15:0]       SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;
    localparam logic [31:0]       DOWN_LOAD = 32'(DOWN_CYCLES - 1);
    localparam logic [31:0]       UP_BASE   = 32'(UP_CYCLES);
    localparam logic [CNT_W-1:0]  RETRY_MAX = CNT_W'(NUM_HOLES - 1);

    typedef enum logic [1:0] {IDLE, DOWN, SPAWN, UP} state_t;

    state_t               state, state_nxt;
    logic [15:0]          lfsr;
    logic [31:0]          timer, timer_nxt;
    logic [NUM_HOLES-1:0] pending, pending_nxt;
    logic [CNT_W-1:0]     target, target_nxt;
    logic [CNT_W-1:0]     retry, retry_nxt;
    logic [NUM_HOLES-1:0] mask_q, mask_nxt;
    logic                 expired_q, expired_nxt;
    logic [7:0]           count_q, count_nxt;
    logic [7:0]           pick_idx;
    logic [NUM_HOLES-1:0] pick_mask, spawn_mask;
    logic                 miss_end;
    logic                 unused_inputs;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_HOLES-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_HOLES; i++) c = c + CNT_W'(m[i]);
        return c;
    endfunction

    // One-hot of the lowest zero bit; only called while some bit is still clear.
    function automatic logic [NUM_HOLES-1:0] lowest_clear(input logic [NUM_HOLES-1:0] m);
        return ~m & (m + NUM_HOLES'(1));
    endfunction

    function automatic logic [31:0] up_load(input logic [2:0] lvl);
        logic [31:0] len;
        len = UP_BASE >> lvl;
        return (len == 32'd0) ? 32'd0 : len - 32'd1;
    endfunction

`ifdef MOLE_HIDE_ON_MISS_EN
    assign miss_end = mif.miss;
`else
    assign miss_end = 1'b0;
`endif

    assign unused_inputs = ^{mif.non_full_clear_hit, mif.miss};

    assign pick_idx  = 8'(32'(lfsr[7:0]) % 32'(NUM_HOLES));
    assign pick_mask = NUM_HOLES'(1) << pick_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            timer     <= '0;
            pending   <= '0;
            target    <= '0;
            retry     <= '0;
            mask_q    <= '0;
            expired_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state     <= state_nxt;
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            timer     <= timer_nxt;
            pending   <= pending_nxt;
            target    <= target_nxt;
            retry     <= retry_nxt;
            mask_q    <= mask_nxt;
            expired_q <= expired_nxt;
            count_q   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        pending_nxt = pending;
        target_nxt  = target;
        retry_nxt   = retry;
        mask_nxt    = mask_q;
        expired_nxt = 1'b0;
        count_nxt   = count_q;
        spawn_mask  = pending;
        case (state)
            IDLE: begin
                mask_nxt = '0;
                if (mif.game_in_progress) begin
                    state_nxt = DOWN;
                    timer_nxt = DOWN_LOAD;
                    count_nxt = '0;
                end
            end
            DOWN: begin
                if (timer == 32'd0) begin
                    state_nxt   = SPAWN;
                    pending_nxt = '0;
                    target_nxt  = CNT_W'(1) + CNT_W'(32'(lfsr[15:8]) % 32'(MAX_MOLES));
                    retry_nxt   = '0;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            SPAWN: begin
                if ((pending & pick_mask) == '0) begin
                    spawn_mask = pending | pick_mask;
                end else if (retry == RETRY_MAX) begin
                    spawn_mask = pending | lowest_clear(pending);
                    retry_nxt  = '0;
                end else begin
                    retry_nxt = retry + CNT_W'(1);
                end
                pending_nxt = spawn_mask;
                // The whole mask is published at once on the edge into UP.
                if (popcount(spawn_mask) == target) begin
                    state_nxt = UP;
                    mask_nxt  = spawn_mask;
                    timer_nxt = up_load(mif.level);
                    count_nxt = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end
            end
            UP: begin
                if (mif.full_clear_hit) begin
                    state_nxt = DOWN;
                    mask_nxt  = '0;
                    timer_nxt = DOWN_LOAD;
                end else if (miss_end || timer == 32'd0) begin
                    state_nxt   = DOWN;
                    mask_nxt    = '0;
                    timer_nxt   = DOWN_LOAD;
                    expired_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!mif.game_in_progress) begin
            state_nxt   = IDLE;
            mask_nxt    = '0;
            expired_nxt = 1'b0;
            pending_nxt = '0;
            count_nxt   = count_q;
        end
    end

    assign mif.mole_positions = mask_q;
    assign mif.round_expired  = expired_q;
    assign mif.round_count    = count_q;
endmodule
